// File: rtl/w5300_bring_up_scheduler.sv
// w5300_bring_up_scheduler
//   Owns the single W5300 host-bus access engine. It hands the engine out in a
//   fixed order: chip hard reset, PLL lock wait, common-register config client,
//   socket config client, and finally the runtime data client.
//   A per-phase watchdog restarts bring-up when a config phase hangs. The
//   number of restarts is bounded; once it is used up the block parks in FAULT.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   soft_restart                  1-cycle pulse: restart bring-up, clear retry_cnt/error
//   w5300_rst_n, cfg_rst_n        W5300 reset pin, reset to both config clients
//   bus_req/bus_addr/bus_wr_data  engine request and muxed {rd/wr, addr}, write data
//   bus_rd_data, bus_op_done      engine read data (wired to clients externally), done pulse
//   com_*  / sock_*               config client enable/done/op_state and addr/data
//   run_req/run_gnt/run_op_done   runtime client handshake, run_addr/run_wr_data
//   ready, error, retry_cnt       status
module w5300_bring_up_scheduler #(
  parameter int unsigned RST_CYCLES    = 200,
  parameter int unsigned LOCK_CYCLES   = 1000000,
  parameter int unsigned PHASE_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [10:0] IDLE_ADDR     = 11'h3fe
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_restart,
  output logic        w5300_rst_n,
  output logic        cfg_rst_n,
  output logic        bus_req,
  output logic [10:0] bus_addr,
  output logic [15:0] bus_wr_data,
  input  logic [15:0] bus_rd_data,
  input  logic        bus_op_done,
  output logic        com_enable,
  input  logic        com_done,
  output logic        com_op_state,
  input  logic [10:0] com_addr,
  input  logic [15:0] com_wr_data,
  output logic        sock_enable,
  input  logic        sock_done,
  output logic        sock_op_state,
  input  logic [10:0] sock_addr,
  input  logic [15:0] sock_wr_data,
  input  logic        run_req,
  output logic        run_gnt,
  output logic        run_op_done,
  input  logic [10:0] run_addr,
  input  logic [15:0] run_wr_data,
  output logic        ready,
  output logic        error,
  output logic [1:0]  retry_cnt
);

  // A single cycle counter serves every timed phase. It is wide enough for the
  // longest of them and for no fewer than 20 bits.
  localparam int unsigned CMAX = (LOCK_CYCLES > PHASE_TIMEOUT) ?
                                 ((LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES) :
                                 ((PHASE_TIMEOUT > RST_CYCLES) ? PHASE_TIMEOUT : RST_CYCLES);
  localparam int CW = ($clog2(CMAX + 1) > 20) ? $clog2(CMAX + 1) : 20;

  // Each phase ends on the cycle whose count (cycles already spent) reaches N-1.
  // A phase of N therefore lasts exactly N cycles.
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] PT_LAST   = CW'(PHASE_TIMEOUT - 1);
  localparam logic [1:0]    MAX_R     = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_HOLD, PLL_WAIT, CFG_COMMON, CFG_SOCKET, RUNNING, FAULT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    retry_q;
  logic          err_q, rdy_q, wrst_q, crst_q;
  logic          com_en_q, sock_en_q, gnt_q, req_q;
  logic          phase_done;

  // Read data goes straight from the engine to every client outside this block.
  logic unused_rd;
  assign unused_rd = ^bus_rd_data;

  assign phase_done = (state_q == CFG_COMMON) ? com_done : sock_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      wrst_q    <= 1'b0;
      crst_q    <= 1'b0;
      com_en_q  <= 1'b0;
      sock_en_q <= 1'b0;
      gnt_q     <= 1'b0;
      req_q     <= 1'b0;
    end else if (soft_restart) begin
      // Restart beats done and timeout in the same cycle.
      state_q   <= RESET_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      wrst_q    <= 1'b0;
      crst_q    <= 1'b0;
      com_en_q  <= 1'b0;
      sock_en_q <= 1'b0;
      gnt_q     <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (cnt_q >= RST_LAST) begin
            state_q <= PLL_WAIT;
            cnt_q   <= '0;
            wrst_q  <= 1'b1;
            crst_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PLL_WAIT: begin
          if (cnt_q >= LOCK_LAST) begin
            state_q  <= CFG_COMMON;
            cnt_q    <= '0;
            com_en_q <= 1'b1;
            req_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CFG_COMMON, CFG_SOCKET: begin
          // Done is checked before the watchdog, so a done in the timeout cycle wins.
          if (phase_done) begin
            cnt_q <= '0;
            if (state_q == CFG_COMMON) begin
              state_q   <= CFG_SOCKET;
              com_en_q  <= 1'b0;
              sock_en_q <= 1'b1;
            end else begin
              state_q   <= RUNNING;
              sock_en_q <= 1'b0;
              req_q     <= 1'b0;
              rdy_q     <= 1'b1;
            end
          end else if (cnt_q >= PT_LAST) begin
            cnt_q     <= '0;
            com_en_q  <= 1'b0;
            sock_en_q <= 1'b0;
            req_q     <= 1'b0;
            if (retry_q < MAX_R) begin
              retry_q <= retry_q + 2'd1;
              state_q <= RESET_HOLD;
              wrst_q  <= 1'b0;
              crst_q  <= 1'b0;
            end else begin
              state_q <= FAULT;
              err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUNNING: begin
          // Grant and request follow run_req one cycle later, in both directions.
          gnt_q <= run_req;
          req_q <= run_req;
        end
        FAULT: ;
        default: state_q <= RESET_HOLD;
      endcase
    end
  end

  // The engine mux is driven by registered ownership, so it adds no latency.
  always_comb begin
    bus_addr    = IDLE_ADDR;
    bus_wr_data = '0;
    if (com_en_q) begin
      bus_addr    = com_addr;
      bus_wr_data = com_wr_data;
    end else if (sock_en_q) begin
      bus_addr    = sock_addr;
      bus_wr_data = sock_wr_data;
    end else if (gnt_q) begin
      bus_addr    = run_addr;
      bus_wr_data = run_wr_data;
    end
  end

  assign com_op_state  = com_en_q  & bus_op_done;
  assign sock_op_state = sock_en_q & bus_op_done;
  assign run_op_done   = gnt_q     & bus_op_done;

  assign w5300_rst_n = wrst_q;
  assign cfg_rst_n   = crst_q;
  assign bus_req     = req_q;
  assign com_enable  = com_en_q;
  assign sock_enable = sock_en_q;
  assign run_gnt     = gnt_q;
  assign ready       = rdy_q;
  assign error       = err_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_w5300_bring_up_scheduler.sv
module tb_w5300_bring_up_scheduler;
  localparam int RST_C  = 20;
  localparam int LOCK_C = 50;
  localparam int PT     = 40;
  localparam int MR     = 3;
  localparam logic [10:0] IDLE = 11'h3fe;

  logic        clk = 1'b0, rst = 1'b1, soft_restart = 1'b0;
  logic        w5300_rst_n, cfg_rst_n, bus_req;
  logic [10:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data = '0;
  logic        bus_op_done = 1'b0;
  logic        com_enable, com_op_state, sock_enable, sock_op_state;
  logic        com_done = 1'b0, sock_done = 1'b0;
  logic [10:0] com_addr = '0, sock_addr = '0, run_addr = '0;
  logic [15:0] com_wr_data = '0, sock_wr_data = '0, run_wr_data = '0;
  logic        run_req = 1'b0, run_gnt, run_op_done;
  logic        ready, error;
  logic [1:0]  retry_cnt;

  always #5 clk = ~clk;

  w5300_bring_up_scheduler #(
    .RST_CYCLES(RST_C), .LOCK_CYCLES(LOCK_C), .PHASE_TIMEOUT(PT), .MAX_RETRY(MR), .IDLE_ADDR(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .soft_restart(soft_restart),
    .w5300_rst_n(w5300_rst_n), .cfg_rst_n(cfg_rst_n), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_op_done(bus_op_done),
    .com_enable(com_enable), .com_done(com_done), .com_op_state(com_op_state),
    .com_addr(com_addr), .com_wr_data(com_wr_data),
    .sock_enable(sock_enable), .sock_done(sock_done), .sock_op_state(sock_op_state),
    .sock_addr(sock_addr), .sock_wr_data(sock_wr_data),
    .run_req(run_req), .run_gnt(run_gnt), .run_op_done(run_op_done),
    .run_addr(run_addr), .run_wr_data(run_wr_data),
    .ready(ready), .error(error), .retry_cnt(retry_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase index (0 hold, 1 pll, 2 common, 3 socket, 4 run,
  // 5 fault) plus cycles spent in the phase, the retry count, the sticky error
  // and the runtime grant.
  int ph, t, retry;
  bit err, gnt;
  bit com_ok, sock_ok, sock_at_to, force_op;
  int run_done_seen;

  task automatic m_reset();
    ph = 0; t = 0; retry = 0; err = 0; gnt = 0;
  endtask

  task automatic model_step();
    if (rst || soft_restart) m_reset();
    else case (ph)
      0: begin t++; if (t >= RST_C)  begin ph = 1; t = 0; end end
      1: begin t++; if (t >= LOCK_C) begin ph = 2; t = 0; end end
      2, 3: begin
        if ((ph == 2) ? com_done : sock_done) begin ph = ph + 1; t = 0; end
        else if (t + 1 >= PT) begin
          t = 0;
          if (retry < MR) begin retry++; ph = 0; end
          else begin ph = 5; err = 1; end
        end else t++;
      end
      4: gnt = run_req;
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    bit oc, os, orn;
    logic [10:0] ea;
    logic [15:0] ed;
    oc = (ph == 2); os = (ph == 3); orn = (ph == 4) && gnt;
    ea = oc ? com_addr : os ? sock_addr : orn ? run_addr : IDLE;
    ed = oc ? com_wr_data : os ? sock_wr_data : orn ? run_wr_data : 16'h0;
    chk("w5300_rst_n", w5300_rst_n, ph != 0);
    chk("cfg_rst_n", cfg_rst_n, ph != 0);
    chk("com_enable", com_enable, oc);
    chk("sock_enable", sock_enable, os);
    chk("run_gnt", run_gnt, orn);
    chk("bus_req", bus_req, oc || os || orn);
    chk("bus_addr", bus_addr, ea);
    chk("bus_wr_data", bus_wr_data, ed);
    chk("com_op_state", com_op_state, oc && bus_op_done);
    chk("sock_op_state", sock_op_state, os && bus_op_done);
    chk("run_op_done", run_op_done, orn && bus_op_done);
    chk("ready", ready, ph == 4);
    chk("error", error, err);
    chk("retry_cnt", retry_cnt, retry);
  endtask

  task automatic drive();
    com_addr     = 11'($urandom); com_wr_data  = 16'($urandom);
    sock_addr    = 11'($urandom); sock_wr_data = 16'($urandom);
    run_addr     = 11'($urandom); run_wr_data  = 16'($urandom);
    bus_rd_data  = 16'($urandom);
    bus_op_done  = force_op ? 1'b1 : ($urandom_range(0, 3) == 0);
    com_done     = com_ok && ($urandom_range(0, 3) == 0);
    if (sock_at_to) sock_done = (ph == 3) && (t == PT - 1);
    else            sock_done = sock_ok && ($urandom_range(0, 3) == 0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      @(negedge clk);
      check_outputs();
      if (run_op_done) run_done_seen++;
      if (force_op && ph == 2) begin
        chk("t6_com_op_state", com_op_state, 1);
        chk("t6_sock_op_state", sock_op_state, 0);
        chk("t6_run_op_done", run_op_done, 0);
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic wait_ph(input int target, input int budget, input string tag);
    int k = 0;
    while (ph != target && k < budget) begin step(1); k++; end
    chk(tag, ph, target);
  endtask

  task automatic wait_retry(input int target, input int budget, input string tag);
    int k = 0;
    while (retry < target && k < budget) begin step(1); k++; end
    chk(tag, retry_cnt, target);
  endtask

  task automatic pulse_soft();
    soft_restart = 1'b1;
    step(1);
    soft_restart = 1'b0;
  endtask

  localparam int TRIP = RST_C + LOCK_C + PT + 10;

  initial begin
    int k;
    m_reset();
    com_ok = 1; sock_ok = 1; sock_at_to = 0; force_op = 0; run_done_seen = 0;

    // Reset values, then full bring-up with measured hold and PLL wait lengths.
    step(3);
    rst = 1'b0;
    k = 0;
    while (!w5300_rst_n && k < 1000) begin step(1); k++; end
    chk("t1_rst_low_cycles", k, RST_C);
    chk("t1_cfg_rst_n", cfg_rst_n, 1);
    k = 0;
    while (!bus_req && k < 1000) begin step(1); k++; end
    chk("t1_pll_wait_cycles", k, LOCK_C);
    wait_ph(4, 4 * TRIP, "t1_reach_running");
    chk("t1_ready", ready, 1);

    // Common config never finishes: three restarts, then FAULT.
    pulse_soft();
    com_ok = 0;
    wait_ph(5, 5 * TRIP, "t2_reach_fault");
    chk("t2_error", error, 1);
    chk("t2_retry", retry_cnt, 3);
    step(10);
    chk("t2_bus_req", bus_req, 0);
    chk("t2_w5300_rst_n", w5300_rst_n, 1);
    chk("t2_error_sticky", error, 1);

    // Socket done lands on the watchdog cycle: done wins, retry unchanged.
    pulse_soft();
    chk("t3_error_cleared", error, 0);
    wait_retry(1, 2 * TRIP, "t3_retry_one");
    com_ok = 1; sock_at_to = 1;
    wait_ph(4, 3 * TRIP, "t3_reach_running");
    sock_at_to = 0;
    chk("t3_ready", ready, 1);
    chk("t3_retry_kept", retry_cnt, 1);

    // Runtime client: grant one cycle late, three ops, then idle address.
    run_done_seen = 0;
    run_req = 1'b1;
    chk("t4_gnt_not_yet", run_gnt, 0);
    step(1);
    chk("t4_gnt_up", run_gnt, 1);
    k = 0;
    while (run_done_seen < 3 && k < 200) begin step(1); k++; end
    chk("t4_run_ops", run_done_seen, 3);
    run_req = 1'b0;
    step(1);
    chk("t4_gnt_down", run_gnt, 0);
    chk("t4_bus_req", bus_req, 0);
    chk("t4_idle_addr", bus_addr, IDLE);

    // Soft restart mid socket config with two retries taken.
    pulse_soft();
    com_ok = 0; sock_ok = 0;
    wait_retry(2, 3 * TRIP, "t5_retry_two");
    com_ok = 1;
    wait_ph(3, TRIP, "t5_reach_socket");
    step(3);
    chk("t5_sock_en_before", sock_enable, 1);
    soft_restart = 1'b1;
    step(1);
    soft_restart = 1'b0;
    chk("t5_sock_en", sock_enable, 0);
    chk("t5_retry_clr", retry_cnt, 0);
    chk("t5_w5300_rst_n", w5300_rst_n, 0);
    chk("t5_bus_req", bus_req, 0);

    // op_done only reaches the current owner.
    com_ok = 0;
    wait_ph(2, TRIP, "t6_reach_common");
    force_op = 1;
    step(3);
    force_op = 0;
    com_ok = 1; sock_ok = 1;
    wait_ph(4, 3 * TRIP, "t6_reach_running");

    // Asynchronous reset while the runtime client holds the bus.
    run_req = 1'b1;
    step(2);
    rst = 1'b1;
    m_reset();
    #1;
    chk("t7_async_ready", ready, 0);
    chk("t7_async_gnt", run_gnt, 0);
    chk("t7_async_bus_req", bus_req, 0);
    chk("t7_async_rst_n", w5300_rst_n, 0);
    chk("t7_async_addr", bus_addr, IDLE);
    run_req = 1'b0;
    step(2);
    rst = 1'b0;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
